// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM encoding, timing constants
// and a width helper.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TIMING = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int CLK_HZ    = 5_000_000;
   // 8 ms is 1/125 of a second
   localparam int TICKS_8MS = CLK_HZ / 125;

   // Minimum index width for n items, never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/debounce_timer.sv
// Shared stability timer: counts while start is high, saturates at TICKS-1,
// and clears whenever start drops.
module debounce_timer #(
   parameter int TICKS = 40000,
   parameter int CW    = 16
)(
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic done
);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || !start) begin
         r_count <= '0;
      end else if (r_count != CW'(TICKS - 1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign done = (r_count == CW'(TICKS - 1));

endmodule

// File: rtl/debounce_arbiter.sv
// Multi-button debouncer sharing one stability timer among all buttons through a
// round-robin grant; emits clean levels plus one-cycle press/release pulses.
module debounce_arbiter
   import debounce_pkg::*;
#(
   parameter int NBTN  = 4,
   parameter int TICKS = TICKS_8MS,
   parameter int CW    = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NBTN-1:0]          btn_raw,
   output logic [NBTN-1:0]          btn_clean,
   output logic [NBTN-1:0]          btn_press,
   output logic [NBTN-1:0]          btn_release,
   output logic                     busy,
   output logic [clog2(NBTN)-1:0]   grant_idx
);

   localparam int IW = clog2(NBTN);

   state_t          r_state, w_state_nxt;
   logic [NBTN-1:0] r_s1_p0, r_sync_p1;
   logic [NBTN-1:0] w_pending;
   logic [IW-1:0]   r_last, w_sel, w_cand;
   logic            r_target;
   logic            w_found, w_bounce, w_grant_ld, w_last_ld, w_commit;
   logic            w_timer_start, w_timer_done;

   // stage p0 -> p1: two-flop synchroniser for the asynchronous pins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_p0   <= '0;
         r_sync_p1 <= '0;
      end else begin
         r_s1_p0   <= btn_raw;
         r_sync_p1 <= r_s1_p0;
      end
   end

   assign w_pending = r_sync_p1 ^ btn_clean;

   // First pending button after the last one served, wrapping around.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_cand  = '0;
      for (int k = 1; k <= NBTN; k++) begin
         w_cand = IW'((int'(r_last) + k) % NBTN);
         if (!w_found && w_pending[w_cand]) begin
            w_found = 1'b1;
            w_sel   = w_cand;
         end
      end
   end

   assign w_bounce      = (r_sync_p1[grant_idx] != r_target);
   assign w_timer_start = (r_state == TIMING);
   assign busy          = (r_state != IDLE);

   debounce_timer #(
      .TICKS (TICKS),
      .CW    (CW)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .start (w_timer_start),
      .done  (w_timer_done)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_ld  = 1'b0;
      w_last_ld   = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt = TIMING;
               w_grant_ld  = 1'b1;
            end
         end
         TIMING: begin
            // a bounce wins even on the cycle the timer completes
            if (w_bounce) begin
               w_state_nxt = IDLE;
               w_last_ld   = 1'b1;
            end else if (w_timer_done) begin
               w_state_nxt = COMMIT;
            end
         end
         COMMIT: begin
            w_state_nxt = IDLE;
            w_commit    = 1'b1;
            w_last_ld   = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // stage p2: registered grant, clean levels and pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_idx   <= '0;
         r_target    <= 1'b0;
         r_last      <= IW'(NBTN - 1);
         btn_clean   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
      end else begin
         btn_press   <= '0;
         btn_release <= '0;
         if (w_grant_ld) begin
            grant_idx <= w_sel;
            r_target  <= r_sync_p1[w_sel];
         end
         if (w_last_ld) r_last <= grant_idx;
         if (w_commit) begin
            btn_clean[grant_idx]   <= r_target;
            btn_press[grant_idx]   <= r_target;
            btn_release[grant_idx] <= ~r_target;
         end
      end
   end

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter: a timestamp-based behavioural model checked
// every cycle, plus hand-computed latency and level expectations.
module tb_debounce_arbiter;

   localparam int NBTN  = 4;
   localparam int TICKS = 16;
   localparam int CW    = 5;

   logic            clk;
   logic            rst;
   logic [NBTN-1:0] btn_raw;
   logic [NBTN-1:0] btn_clean, btn_press, btn_release;
   logic            busy;
   logic [1:0]      grant_idx;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   debounce_arbiter #(
      .NBTN  (NBTN),
      .TICKS (TICKS),
      .CW    (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn_clean   (btn_clean),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .busy        (busy),
      .grant_idx   (grant_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: the owner is granted at cycle g; it commits in cycle g+TICKS+1 unless its
   // synchronised level departs from the target in any cycle g+1..g+TICKS.
   logic [NBTN-1:0] m_s1, m_sync, m_clean, e_press, e_rel;
   int              m_owner, m_last, m_gc;
   bit              m_active, m_target, m_ok;

   task automatic model_step();
      logic [NBTN-1:0] pend;
      int age;
      if (rst) begin
         m_s1 = '0; m_sync = '0; m_clean = '0; e_press = '0; e_rel = '0;
         m_active = 0; m_owner = 0; m_last = NBTN - 1; m_ok = 1;
      end else begin
         e_press = '0;
         e_rel   = '0;
         if (!m_active) begin
            pend = m_sync ^ m_clean;
            if (pend != 0) begin
               for (int k = 1; k <= NBTN; k++) begin
                  if (pend[(m_last + k) % NBTN]) begin
                     m_owner = (m_last + k) % NBTN;
                     break;
                  end
               end
               m_target = m_sync[m_owner];
               m_gc     = cyc;
               m_active = 1;
            end
         end else begin
            age = cyc - m_gc;
            if (age <= TICKS) begin
               if (m_sync[m_owner] != m_target) begin
                  m_active = 0;
                  m_last   = m_owner;
               end
            end else begin
               m_clean[m_owner] = m_target;
               if (m_target) e_press[m_owner] = 1'b1;
               else          e_rel[m_owner]   = 1'b1;
               m_active = 0;
               m_last   = m_owner;
            end
         end
         m_sync = m_s1;
         m_s1   = btn_raw;
      end
   endtask

   initial begin
      m_ok = 0;
      forever begin
         @(posedge clk);
         model_step();
         cyc = cyc + 1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_ok) begin
            chk("cyc_clean",   int'(btn_clean),   int'(m_clean));
            chk("cyc_press",   int'(btn_press),   int'(e_press));
            chk("cyc_release", int'(btn_release), int'(e_rel));
            chk("cyc_busy",    int'(busy),        int'(m_active));
            chk("cyc_grant",   int'(grant_idx),   m_owner);
            chk("cyc_onepulse", int'($countones({btn_press, btn_release}) <= 1), 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_pulse(input bit rel, input int idx, output int at);
      at = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (rel ? btn_release[idx] : btn_press[idx]) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         total++;
         bad++;
         $display("FAIL pulse_timeout: button %0d release=%0d got none expected one", idx, rel);
      end
   endtask

   initial begin
      int c0, r0, at;
      rst = 1'b1;
      btn_raw = '0;
      repeat (3) tick();
      rst = 1'b0;

      // idle after reset
      repeat (50) tick();
      chk("idle_clean", int'(btn_clean), 0);
      chk("idle_busy",  int'(busy), 0);
      chk("idle_grant", int'(grant_idx), 0);

      // clean press of button 0
      btn_raw[0] = 1'b1;
      c0 = cyc;
      wait_pulse(0, 0, at);
      chk("press0_latency", at - c0, 20);
      chk("press0_vector", int'(btn_press), 1);
      @(negedge clk);
      chk("press0_width", int'(btn_press), 0);
      chk("press0_clean", int'(btn_clean), 1);

      // button 1 bounces once, then settles high
      tick();
      btn_raw[1] = 1'b1;
      c0 = cyc;
      repeat (5) tick();
      btn_raw[1] = 1'b0;
      repeat (3) tick();
      btn_raw[1] = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      wait_pulse(0, 1, at);
      chk("press1_latency", at - c0, 28);

      // buttons 2 and 3 together; 2 first, 3 granted right after 2 commits
      tick();
      btn_raw[3:2] = 2'b11;
      c0 = cyc;
      wait_pulse(0, 2, at);
      chk("press2_latency", at - c0, 20);
      chk("press2_vector", int'(btn_press), 4);
      chk("press2_grant", int'(grant_idx), 2);
      @(negedge clk);
      chk("grant3_idx", int'(grant_idx), 3);
      chk("grant3_busy", int'(busy), 1);
      chk("press2_width", int'(btn_press), 0);
      wait_pulse(0, 3, at);
      chk("press3_latency", at - c0, 38);

      // release of button 0
      tick();
      btn_raw[0] = 1'b0;
      c0 = cyc;
      wait_pulse(1, 0, at);
      chk("release0_latency", at - c0, 20);
      chk("release0_nopress", int'(btn_press), 0);
      @(negedge clk);
      chk("release0_clean", int'(btn_clean), 4'b1110);
      chk("release0_width", int'(btn_release), 0);

      // reset while button 2's release is being timed; buttons 1 and 3 still held
      tick();
      btn_raw[2] = 1'b0;
      c0 = cyc;
      repeat (10) tick();
      @(negedge clk);
      chk("mid_busy", int'(busy), 1);
      tick();
      rst = 1'b1;
      r0 = cyc;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_clean", int'(btn_clean), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pulses", int'({btn_press, btn_release}), 0);
      wait_pulse(0, 1, at);
      chk("rst_press1_latency", at - r0, 21);
      wait_pulse(0, 3, at);
      chk("rst_press3_latency", at - r0, 39);
      repeat (10) tick();
      chk("final_clean", int'(btn_clean), 4'b1010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
